// File: rtl/snes_pkg.sv
// Shared constants, state encoding and shift-word helper for the SNES pad emulator.
package snes_pkg;

    localparam int SNES_FRAME_BITS   = 16;
    localparam int SNES_BUTTON_COUNT = 12;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_N      = 4;
    localparam int BTN_S      = 5;
    localparam int BTN_W      = 6;
    localparam int BTN_E      = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } snes_state_e;

    // Wire format is active-low; the four unused trailing bits always read released.
    function automatic logic [SNES_FRAME_BITS-1:0] snes_word(
        input logic [SNES_BUTTON_COUNT-1:0] pressed
    );
        return {4'b1111, ~pressed};
    endfunction

endpackage

// File: rtl/sync_edge.sv
// N-flop synchronizer for one asynchronous pin, with single-cycle rise/fall pulses.
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
        prev_d = sync_q[STAGES-1];
    end

    // Reset to the pin's idle level so release from reset never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/snes_controller_emulator.sv
// SNES pad responder: latch loads the button word, console clock shifts it out active-low.
// Optional turbo feature is enabled by defining SNES_EMU_TURBO_EN.
module snes_controller_emulator
    import snes_pkg::*;
#(
    parameter int LINK_TIMEOUT = 2_500_000,
    parameter int SYNC_STAGES  = 2
`ifdef SNES_EMU_TURBO_EN
    ,
    parameter int TURBO_FRAMES = 4
`endif
) (
    input  logic        clk_50,
    input  logic        reset,
    input  logic        ctrl_latch,
    input  logic        ctrl_clk,
    input  logic [11:0] buttons,
`ifdef SNES_EMU_TURBO_EN
    input  logic [11:0] turbo_mask,
`endif
    output logic        ctrl_dout,
    output logic        frame_done,
    output logic        link_active,
    output logic [4:0]  bit_index,
    output logic [1:0]  dbg_state
);

    localparam logic [4:0] LAST_IDX = 5'(SNES_FRAME_BITS - 1);

    logic latch_rise, latch_fall;
    logic clk_rise, clk_fall_unused;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_latch (
        .clk      (clk_50),
        .rst      (reset),
        .async_in (ctrl_latch),
        .rise     (latch_rise),
        .fall     (latch_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_clk (
        .clk      (clk_50),
        .rst      (reset),
        .async_in (ctrl_clk),
        .rise     (clk_rise),
        .fall     (clk_fall_unused)
    );

    logic [11:0] buttons_eff;

`ifdef SNES_EMU_TURBO_EN
    // Frame counter runs 1..TURBO_FRAMES; the window flips on the latch that starts a new run.
    logic [31:0] tframe_q, tframe_d;
    logic        twin_q, twin_d;

    always_comb begin
        tframe_d = tframe_q;
        twin_d   = twin_q;
        if (latch_rise) begin
            if (tframe_q >= 32'(TURBO_FRAMES)) begin
                tframe_d = 32'd1;
                twin_d   = ~twin_q;
            end else begin
                tframe_d = tframe_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            tframe_q <= 32'd0;
            twin_q   <= 1'b0;
        end else begin
            tframe_q <= tframe_d;
            twin_q   <= twin_d;
        end
    end

    assign buttons_eff = buttons & ~(turbo_mask & {12{twin_q}});
`else
    assign buttons_eff = buttons;
`endif

    snes_state_e state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  idx_q, idx_d;
    logic        done_q, done_d;
    logic [31:0] link_cnt_q, link_cnt_d;

    // Latch rise is checked before clock rise in every state, so it wins a same-cycle tie.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (latch_rise) begin
                    state_d = ST_LOAD;
                    shift_d = snes_word(buttons_eff);
                    idx_d   = 5'd0;
                end
            end
            ST_LOAD: begin
                shift_d = snes_word(buttons_eff);
                idx_d   = 5'd0;
                if (latch_fall) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (latch_rise) begin
                    state_d = ST_LOAD;
                    shift_d = snes_word(buttons_eff);
                    idx_d   = 5'd0;
                end else if (clk_rise) begin
                    shift_d = {1'b1, shift_q[15:1]};
                    idx_d   = idx_q + 5'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (latch_rise) begin
                    state_d = ST_LOAD;
                    shift_d = snes_word(buttons_eff);
                    idx_d   = 5'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        link_cnt_d = link_cnt_q;
        if (latch_rise) link_cnt_d = 32'(LINK_TIMEOUT);
        else if (link_cnt_q != 32'd0) link_cnt_d = link_cnt_q - 32'd1;
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= 16'hFFFF;
            idx_q      <= 5'd0;
            done_q     <= 1'b0;
            link_cnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
            link_cnt_q <= link_cnt_d;
        end
    end

    // A real pad drives low once its shift register has emptied.
    always_comb begin
        ctrl_dout = 1'b1;
        case (state_q)
            ST_IDLE:  ctrl_dout = 1'b1;
            ST_LOAD:  ctrl_dout = shift_q[0];
            ST_SHIFT: ctrl_dout = shift_q[0];
            ST_DONE:  ctrl_dout = 1'b0;
            default:  ctrl_dout = 1'b1;
        endcase
    end

    assign frame_done  = done_q;
    assign link_active = (link_cnt_q != 32'd0);
    assign bit_index   = idx_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/snes_controller_emulator.md
# snes_controller_emulator

Responder end of the SNES controller serial link: presents a 12-button vector to an external console (or a second board running our controller-reader host) as if it were a physical pad. Samples the console-driven `latch` and clock lines in the `clk_50` domain, parallel-loads the button word on latch, and shifts active-low bits out on `dout` on each rising controller-clock edge. Sits between the game-logic button sources and the controller connector pins.

## Interface
- `LINK_TIMEOUT`, default 2_500_000: `clk_50` cycles without a latch pulse before `link_active` drops (50 ms).
- `SYNC_STAGES`, default 2: synchronizer flops per asynchronous input. Minimum 2.
- `clk_50`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `ctrl_latch`  in  1  console latch, asynchronous, active-high.
- `ctrl_clk`  in  1  console shift clock, asynchronous, idles high.
- `buttons`  in  12  pressed = 1. Bit order [0]B [1]Y [2]SELECT [3]START [4]N [5]S [6]W [7]E [8]A [9]X [10]L [11]R.
- `ctrl_dout`  out  1  serial data to console, active-low (0 = pressed).
- `frame_done`  out  1  one-cycle pulse after the 16th bit has been shifted out.
- `link_active`  out  1  high while latches arrive within `LINK_TIMEOUT`.
- `bit_index`  out  5  bit currently presented on `ctrl_dout` (0..16; 16 = exhausted).

## Operation
- 16-bit shift word = {4'b1111, ~buttons}. Bit 0 (B) goes out first; bits 12-15 always read "released".
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE (after reset): `ctrl_dout`=1, `bit_index`=0. Rising latch -> LOAD.
- LOAD: while synced latch is high, reload the shift word from `buttons` every cycle; `ctrl_dout` = bit 0; clock edges ignored. Falling latch -> SHIFT, `bit_index`=0.
- SHIFT: each synced rising edge of `ctrl_clk` shifts right by one, `bit_index`+1. When `bit_index` reaches 16 -> DONE, pulse `frame_done`.
- DONE: `ctrl_dout`=0 (matches a real pad after 16 clocks); extra clock edges ignored, `bit_index` held at 16.
- Rising latch from SHIFT or DONE -> LOAD (aborts any partial frame, no `frame_done`).
- Same-cycle latch rise and clock rise: latch wins.
- `link_active`: 32-bit counter cleared to `LINK_TIMEOUT` on each synced rising latch, decremented to 0 otherwise; `link_active` = (counter != 0). Saturates at 0.

## Timing
- Reset values: `ctrl_dout`=1, `frame_done`=0, `link_active`=0, `bit_index`=0, state IDLE, timeout counter 0.
- Input to internal edge detect: `SYNC_STAGES`+1 cycles. With defaults, `ctrl_dout` updates 3 `clk_50` cycles (60 ns) after a pin-level `ctrl_clk` rise or latch fall; well within the 6 µs half-period driven by our host reader, which samples on its falling clock edge.
- `buttons` sampled on the last LOAD cycle; changes during SHIFT do not affect the frame in flight.
- `frame_done` asserted the cycle `bit_index` becomes 16.
- Reset mid-frame returns to IDLE immediately, asynchronously.

## Configuration
- `SNES_EMU_TURBO_EN`: when defined, adds input `turbo_mask` [11:0] and parameter `TURBO_FRAMES` (default 4). A button with its mask bit set is reported pressed only during alternating windows of `TURBO_FRAMES` latches (frame counter advances on each rising latch, window toggles on wrap). Unmasked buttons unaffected. Undefined: no port, no counter, `buttons` used directly.

## Structure
- Shared package `snes_pkg`: button bit-index constants (B..R), `SNES_FRAME_BITS`=16, `SNES_BUTTON_COUNT`=12, state enum.
- One sub-module: `sync_edge` (N-flop synchronizer plus rise/fall pulse outputs), instantiated for `ctrl_latch` and `ctrl_clk`.

## Test plan
- `buttons`=12'h001 (B), 12 µs latch, 16 clock pulses at 6 µs half-period -> sampled serial 0,1,1,...,1 (16 bits), `frame_done` pulses once, `ctrl_dout`=0 afterward.
- `buttons`=12'hFFF -> bits 0-11 read 0, bits 12-15 read 1, bit 16+ reads 0.
- Latch reasserted after 5 clocks -> frame restarts at bit 0 with freshly loaded buttons, no `frame_done` for aborted frame.
- `buttons` changed from 12'h100 to 12'h000 mid-SHIFT -> in-flight frame still reports A pressed at bit 8.
- No latch for `LINK_TIMEOUT`+1 cycles -> `link_active` falls; one latch -> rises within 4 cycles.
- Turbo build, `turbo_mask`=12'h001, B held, `TURBO_FRAMES`=4 -> B reads pressed for 4 frames, released for 4, repeating.
